// File: rtl/nn_pool_f0_pkg.sv
// Shared constants and FSM encoding for the f0 max-pooling stage.
package nn_pool_f0_pkg;
    localparam int unsigned PW        = 2;
    localparam int unsigned DIM       = 8;
    localparam int unsigned NMAP      = 4;
    localparam int unsigned POOL_DIM  = DIM / 2;
    localparam int unsigned NWIN      = POOL_DIM * POOL_DIM;
    localparam int unsigned SUM_W     = 6;
    localparam int unsigned MAP_BITS  = PW * DIM * DIM;
    localparam int unsigned POOL_BITS = PW * NWIN;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POOL = 2'd1,
        DONE = 2'd2
    } state_t;
endpackage

// File: rtl/nn_pool_f0_max4.sv
// Combinational maximum of four unsigned pixel values.
module pool_max4
    import nn_pool_f0_pkg::*;
#(
    parameter int unsigned W = PW
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    input  logic [W-1:0] d,
    output logic [W-1:0] y
);
    logic [W-1:0] ab;
    logic [W-1:0] cd;

    always_comb begin
        ab = (a >= b) ? a : b;
        cd = (c >= d) ? c : d;
        y  = (ab >= cd) ? ab : cd;
    end
endmodule

// File: rtl/nn_pool_f0.sv
// 2x2/stride-2 max pooling of four 8x8 maps, one window per cycle across all maps,
// with a running per-map sum of the pooled values.
module nn_pool_f0
    import nn_pool_f0_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] in1,
    input  logic [255:0] in2,
    output logic         busy,
    output logic         done,
    output logic         out_valid,
    output logic [127:0] pool_out,
    output logic [23:0]  sum_out
);
    state_t                     state;
    logic [NMAP*MAP_BITS-1:0]   buf_q;
    logic [3:0]                 w;
    int unsigned                win_off;
    logic [PW-1:0]              px [NMAP][4];
    logic [PW-1:0]              mx [NMAP];

    // Top-left pixel of window (i,j) sits at row 2i, column 2j of each map.
    always_comb begin
        win_off = PW * (2 * DIM * 32'(w[3:2]) + 2 * 32'(w[1:0]));
        for (int unsigned m = 0; m < NMAP; m++) begin
            px[m][0] = buf_q[m*MAP_BITS + win_off +: PW];
            px[m][1] = buf_q[m*MAP_BITS + win_off + PW +: PW];
            px[m][2] = buf_q[m*MAP_BITS + win_off + PW*DIM +: PW];
            px[m][3] = buf_q[m*MAP_BITS + win_off + PW*(DIM+1) +: PW];
        end
    end

    for (genvar g = 0; g < NMAP; g++) begin : g_max
        pool_max4 #(.W(PW)) u_max (
            .a (px[g][0]),
            .b (px[g][1]),
            .c (px[g][2]),
            .d (px[g][3]),
            .y (mx[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            buf_q     <= '0;
            w         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            out_valid <= 1'b0;
            pool_out  <= '0;
            sum_out   <= '0;
        end else begin
            case (state)
                POOL: begin
                    for (int unsigned m = 0; m < NMAP; m++) begin
                        pool_out[m*POOL_BITS + PW*32'(w) +: PW] <= mx[m];
                        sum_out[m*SUM_W +: SUM_W] <= sum_out[m*SUM_W +: SUM_W]
                                                     + {{(SUM_W-PW){1'b0}}, mx[m]};
                    end
                    w <= w + 4'd1;
                    if (32'(w) == NWIN - 1) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        buf_q     <= {in2, in1};
                        pool_out  <= '0;
                        sum_out   <= '0;
                        out_valid <= 1'b0;
                        w         <= '0;
                        busy      <= 1'b1;
                        state     <= POOL;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_nn_pool_f0.sv
// Directed self-checking bench for nn_pool_f0.
module tb_nn_pool_f0;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [255:0] in1;
    logic [255:0] in2;
    logic         busy;
    logic         done;
    logic         out_valid;
    logic [127:0] pool_out;
    logic [23:0]  sum_out;

    int checks   = 0;
    int failures = 0;

    // Pattern A: map0 pixel (1,1)=3, map3 pixel (7,7)=2
    localparam logic [255:0] A_IN1  = 256'd3 << 18;
    localparam logic [255:0] A_IN2  = 256'd2 << 254;
    localparam logic [127:0] A_POOL = (128'd3) | (128'd2 << 126);
    localparam logic [23:0]  A_SUM  = 24'd3 | (24'd2 << 18);
    // Pattern B: map1 (0,0)=1,(0,1)=2 -> slot 0 = 2; map2 (6,0)=3 -> slot 12 = 3
    localparam logic [255:0] B_IN1  = (256'd1 << 128) | (256'd2 << 130);
    localparam logic [255:0] B_IN2  = 256'd3 << 96;
    localparam logic [127:0] B_POOL = (128'd2 << 32) | (128'd3 << 88);
    localparam logic [23:0]  B_SUM  = (24'd2 << 6) | (24'd3 << 12);
    localparam logic [23:0]  ONES_SUM = {4{6'd48}};

    nn_pool_f0 dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in1       (in1),
        .in2       (in2),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .pool_out  (pool_out),
        .sum_out   (sum_out)
    );

    always #5 clk = ~clk;

    // Called #1 after an edge; the following edge captures.
    task automatic drive_start(input logic [255:0] a, input logic [255:0] b);
        start = 1'b1;
        in1   = a;
        in2   = b;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (k < 40) begin
            @(posedge clk); #1;
            k++;
            if (done) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; in1 = A_IN1; in2 = A_IN2;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (pool_out !== 128'd0) begin failures++; $display("FAIL reset_pool got=%h exp=0", pool_out); end
        checks++; if (sum_out !== 24'd0) begin failures++; $display("FAIL reset_sum got=%h exp=0", sum_out); end
        rst = 1'b0; start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_nocapture got=%b exp=0", busy); end
    endtask

    task automatic test_sparse;
        int k;
        drive_start(A_IN1, A_IN2);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL sparse_busy got=%b exp=1", busy); end
        in1 = '0; in2 = '0;
        wait_done(k);
        checks++; if (k !== 16) begin failures++; $display("FAIL sparse_latency got=%0d exp=16", k); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL sparse_busy_end got=%b exp=0", busy); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL sparse_valid got=%b exp=1", out_valid); end
        checks++; if (pool_out !== A_POOL) begin failures++; $display("FAIL sparse_pool got=%h exp=%h", pool_out, A_POOL); end
        checks++; if (sum_out !== A_SUM) begin failures++; $display("FAIL sparse_sum got=%h exp=%h", sum_out, A_SUM); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL done_pulse got=%b exp=0", done); end
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL valid_hold got=%b exp=1", out_valid); end
        checks++; if (pool_out !== A_POOL) begin failures++; $display("FAIL pool_hold got=%h exp=%h", pool_out, A_POOL); end
    endtask

    task automatic test_all_ones;
        int k;
        drive_start('1, '1);
        wait_done(k);
        checks++; if (k !== 16) begin failures++; $display("FAIL ones_latency got=%0d exp=16", k); end
        checks++; if (pool_out !== {128{1'b1}}) begin failures++; $display("FAIL ones_pool got=%h exp=all-ones", pool_out); end
        checks++; if (sum_out !== ONES_SUM) begin failures++; $display("FAIL ones_sum got=%h exp=%h", sum_out, ONES_SUM); end
        @(posedge clk); #1;
    endtask

    task automatic test_start_ignored;
        int k;
        drive_start(A_IN1, A_IN2);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b1; in1 = '1; in2 = '1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ignored_busy got=%b exp=1", busy); end
        wait_done(k);
        checks++; if (k + 6 !== 16) begin failures++; $display("FAIL ignored_latency got=%0d exp=16", k + 6); end
        checks++; if (pool_out !== A_POOL) begin failures++; $display("FAIL ignored_pool got=%h exp=%h", pool_out, A_POOL); end
        checks++; if (sum_out !== A_SUM) begin failures++; $display("FAIL ignored_sum got=%h exp=%h", sum_out, A_SUM); end
    endtask

    // Enters with done high from the previous run.
    task automatic test_back_to_back;
        int k;
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done_pre got=%b exp=1", done); end
        drive_start(B_IN1, B_IN2);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid got=%b exp=0", out_valid); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL b2b_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy got=%b exp=1", busy); end
        checks++; if (pool_out !== 128'd0) begin failures++; $display("FAIL b2b_clear got=%h exp=0", pool_out); end
        wait_done(k);
        checks++; if (k !== 16) begin failures++; $display("FAIL b2b_latency got=%0d exp=16", k); end
        checks++; if (pool_out !== B_POOL) begin failures++; $display("FAIL b2b_pool got=%h exp=%h", pool_out, B_POOL); end
        checks++; if (sum_out !== B_SUM) begin failures++; $display("FAIL b2b_sum got=%h exp=%h", sum_out, B_SUM); end
        @(posedge clk); #1;
    endtask

    task automatic test_mid_reset;
        int k;
        drive_start('1, '1);
        repeat (8) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
        checks++; if (pool_out !== 128'd0) begin failures++; $display("FAIL midrst_pool got=%h exp=0", pool_out); end
        checks++; if (sum_out !== 24'd0) begin failures++; $display("FAIL midrst_sum got=%h exp=0", sum_out); end
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_idle got=%b exp=0", busy); end
        drive_start(A_IN1, A_IN2);
        wait_done(k);
        checks++; if (k !== 16) begin failures++; $display("FAIL midrst_latency got=%0d exp=16", k); end
        checks++; if (pool_out !== A_POOL) begin failures++; $display("FAIL midrst_pool2 got=%h exp=%h", pool_out, A_POOL); end
        checks++; if (sum_out !== A_SUM) begin failures++; $display("FAIL midrst_sum2 got=%h exp=%h", sum_out, A_SUM); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0;
        test_reset;
        test_sparse;
        test_all_ones;
        test_start_ignored;
        test_back_to_back;
        test_mid_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
